// File: rtl/ec_point_encoder.sv
// SEC1 point encoder: captures an affine point and streams 0x04||X||Y, 0x02/03||X or 0x00 bytewise.
// Prefix byte is valid the cycle after capture; out_ready low stalls the frame in place, no input queuing.
module ec_point_encoder #(
  parameter int COORD_BYTES = 32,
  parameter int LEN_W       = 10
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [8*COORD_BYTES-1:0] in_x,
  input  logic [8*COORD_BYTES-1:0] in_y,
  input  logic                     in_compress,
  input  logic                     in_infinity,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [7:0]               out_data,
  output logic                     out_last,
  output logic [LEN_W-1:0]         out_len
);

  localparam int CW = $clog2(COORD_BYTES + 1);
  localparam int IW = (COORD_BYTES > 1) ? $clog2(COORD_BYTES) : 1;
  localparam logic [CW-1:0]    CNT_MAX = CW'(COORD_BYTES - 1);
  localparam logic [LEN_W-1:0] LEN_INF = LEN_W'(1);
  localparam logic [LEN_W-1:0] LEN_CMP = LEN_W'(COORD_BYTES + 1);
  localparam logic [LEN_W-1:0] LEN_UNC = LEN_W'(2 * COORD_BYTES + 1);

  typedef enum logic [1:0] {IDLE, HDR, XB, YB} state_t;

  // Coordinates as byte arrays: element COORD_BYTES-1 is the first byte on the wire.
  typedef struct packed {
    logic [COORD_BYTES-1:0][7:0] x;
    logic [COORD_BYTES-1:0][7:0] y;
    logic                        compress;
    logic                        infinity;
  } point_t;

  state_t           state_q, state_d;
  point_t           pt_q, pt_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             cnt_zero;

  assign cnt_zero = (cnt_q == '0);
  assign out_len  = len_q;

  always_comb begin
    state_d   = state_q;
    pt_d      = pt_q;
    len_d     = len_q;
    cnt_d     = cnt_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_data  = 8'h00;
    out_last  = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          pt_d.x        = in_x;
          pt_d.y        = in_y;
          pt_d.compress = in_compress;
          pt_d.infinity = in_infinity;
          len_d   = in_infinity ? LEN_INF : (in_compress ? LEN_CMP : LEN_UNC);
          state_d = HDR;
        end
      end
      HDR: begin
        out_valid = 1'b1;
        if (pt_q.infinity) begin
          out_data = 8'h00;
          out_last = 1'b1;
        end else if (pt_q.compress) begin
          out_data = {7'b0000001, pt_q.y[0][0]};
        end else begin
          out_data = 8'h04;
        end
        if (out_ready) begin
          state_d = pt_q.infinity ? IDLE : XB;
          cnt_d   = pt_q.infinity ? '0 : CNT_MAX;
        end
      end
      XB: begin
        out_valid = 1'b1;
        out_data  = pt_q.x[IW'(cnt_q)];
        out_last  = pt_q.compress && cnt_zero;
        if (out_ready) begin
          if (cnt_zero) begin
            state_d = pt_q.compress ? IDLE : YB;
            cnt_d   = pt_q.compress ? '0 : CNT_MAX;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
      end
      YB: begin
        out_valid = 1'b1;
        out_data  = pt_q.y[IW'(cnt_q)];
        out_last  = cnt_zero;
        if (out_ready) begin
          if (cnt_zero) state_d = IDLE;
          else          cnt_d   = cnt_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pt_q    <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pt_q    <= pt_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: doc/ec_point_encoder.md
# ec_point_encoder

Serialises an affine elliptic-curve point into its SEC1 octet-string encoding as a byte stream. Sits directly downstream of the scalar-multiply / point-arithmetic unit, which delivers full-width X and Y coordinates. It feeds the public-key export path, which consumes encoded public-key bytes. Supports uncompressed (`0x04||X||Y`), compressed (`0x02/0x03||X`) and point-at-infinity (`0x00`) encodings, with coordinates zero-padded big-endian to the curve byte size.

## Interface

Parameters:
- `COORD_BYTES`, default 32: coordinate size in bytes (32 for P-256, 48 for P-384, 66 for P-521); legal range 1..255.
- `LEN_W`, default 10: width of `out_len`; must hold `2*COORD_BYTES+1`.

Ports:
- `clk`  in  1  single clock; all logic is rising-edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `in_valid`  in  1  point request valid.
- `in_ready`  out  1  block can accept a point.
- `in_x`  in  8*COORD_BYTES  affine X, big-endian (MSB = first output byte).
- `in_y`  in  8*COORD_BYTES  affine Y, big-endian.
- `in_compress`  in  1  1 = compressed form.
- `in_infinity`  in  1  1 = point at infinity; X/Y ignored.
- `out_valid`  out  1  output byte valid.
- `out_ready`  in  1  consumer accepts byte.
- `out_data`  out  8  encoded byte.
- `out_last`  out  1  final byte of the encoding.
- `out_len`  out  LEN_W  total encoding length; valid on every beat of the frame.

## Operation

- Input handshake: transfer when `in_valid && in_ready`. On transfer, capture `in_x`, `in_y`, `in_compress` and `in_infinity` into internal registers. Inputs may change afterwards.
- Output handshake follows valid/ready rules:
  - A beat transfers when `out_valid && out_ready`.
  - While `out_valid && !out_ready`, `out_data`, `out_last` and `out_len` hold stable.
  - `out_valid` never drops without a transfer, except on reset.
- FSM states:
  - IDLE: `in_ready=1`, `out_valid=0`. On transfer: if infinity, go to HDR with `len=1`; else go to HDR with `len = compress ? 1+CB : 1+2*CB`.
  - HDR: emit prefix byte.
    - Infinity: emit `0x00` with `out_last=1`, then go to IDLE.
    - Compressed: emit `0x02 | y[0]`, then go to XB.
    - Uncompressed: emit `0x04`, then go to XB.
  - XB: emit X bytes, index `COORD_BYTES-1` down to 0. Byte counter `cnt` (width `$clog2(COORD_BYTES+1)`) is loaded with `COORD_BYTES-1` and decrements per transfer. At `cnt==0`: compressed sets `out_last=1` and goes to IDLE; uncompressed goes to YB with `cnt` reloaded.
  - YB: emit Y bytes MSB first. `cnt==0` sets `out_last=1`, then go to IDLE.
- The byte-select mux indexes the captured register by `cnt`. No leading-zero stripping: a coordinate with zero high bytes still emits exactly `COORD_BYTES` bytes.
- `out_len` is registered at capture and held until the next capture.
- `in_infinity` has priority over `in_compress`.
- `in_ready` is 0 in every state except IDLE, so there is no input queuing.

## Timing

- Reset (`rst_n=0` at a clock edge):
  - FSM goes to IDLE; `cnt=0`.
  - `in_ready=1`, `out_valid=0`, `out_data=0x00`, `out_last=0`, `out_len=0`.
  - Captured coordinates are cleared to 0.
- Reset mid-frame: the frame is abandoned with no `out_last`, and the next point starts from HDR.
- Latency: input transfer at edge T puts the prefix byte on `out_valid` from T+1, with no combinational in→out path.
- With `out_ready` held high, one byte per cycle. A frame of L bytes occupies cycles T+1..T+L.
- `in_ready` rises the cycle after the last-beat transfer (T+L+1). Sustained throughput is one point per L+1 cycles.
- Backpressure: each low cycle of `out_ready` stalls the FSM and `cnt` by one cycle. Nothing is dropped or duplicated.
- `in_valid` during a non-IDLE state is ignored; the upstream holds it until `in_ready`.

## Test plan

- **P-256 G uncompressed.**
  - Stimulus (CB=32): X=6B17D1F2E12C4247F8BCE6E563A440F277037D812DEB33A0F4A13945D898C296, Y=4FE342E2FE1A7F9B8EE7EB4A7C0F9E162BCE33576B315ECECBB6406837BF51F5, compress=0, `out_ready=1`.
  - Required: 65 beats, `out_len=65`; bytes 04,6B,17…96,4F,E3…51,F5; `out_last` only on beat 65 (0xF5); first beat at T+1; `in_ready` high at T+66.
- **Same point, compress=1.**
  - Required: 33 beats, `out_len=33`; first byte 0x03 (Y odd), then X; last byte 0x96.
- **Infinity** (infinity=1, compress=1, X/Y arbitrary).
  - Required: single beat 0x00, `out_last=1`, `out_len=1`.
- **Leading zeros and even Y.**
  - Stimulus: X=0x…0001 (31 zero bytes then 01), Y=0x…0002, compressed.
  - Required: 02, then 31×00, then 01; 33 beats.
- **Random backpressure** (`out_ready` 50% random, uncompressed G).
  - Required: byte sequence identical to the first scenario; data/last/len stable during every stall; `in_valid` pulses during the frame are not accepted.
- **Mid-frame reset.**
  - Stimulus: assert `rst_n=0` after beat 10 of the first scenario, then release and resend G.
  - Required: outputs at reset values the cycle after the reset edge; the resent frame is a complete, correct 65-byte encoding.
